rf_commit_buffer: RTL

In-order retirement buffer that is the write-side master of the architectural register file.
- Decode allocates one entry per destination-writing instruction, in program order.
- Execution units return results out of order, by tag.
- The head entry retires once its result is present and drives the register-file write port (wen/waddr/wdata), one retirement per cycle.
- x0 writes are suppressed. A flush discards all pending entries.

---
 rtl/commit_pkg.sv | 26 ++
 rtl/rf_commit_buffer_wrap_ptr.sv | 40 ++++
 rtl/rf_commit_buffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/commit_pkg.sv
// Shared types and defaults for the in-order commit buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package commit_pkg;

  // Default geometry of the buffer and the register file it writes.
  localparam int DEPTH_DEF          = 8;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF     = 32;

  // Architectural x0 is hard-wired to zero; writes to it are suppressed.
  localparam int X0_ADDR = 0;

  // One buffer slot at default widths:
  //   valid - slot holds an allocated, not yet retired instruction
  //   done  - its result has been written back
  //   rd    - destination register
  //   data  - result value
  typedef struct packed {
    logic                          valid;
    logic                          done;
    logic [REG_ADDR_WIDTH_DEF-1:0] rd;
    logic [DATA_WIDTH_DEF-1:0]     data;
  } commit_entry_t;

endpackage

// File: rtl/rf_commit_buffer_wrap_ptr.sv
// Circular-buffer pointer: index bits plus one wrap bit above them.
// Latency: new value visible the cycle after inc/clr is sampled.
// Backpressure: none; caller gates inc. clr wins over inc.
module wrap_ptr #(
  parameter int PTR_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] ptr
);

  logic [PTR_WIDTH-1:0] ptr_q;
  logic [PTR_WIDTH-1:0] ptr_d;

  // Next pointer: clear first, otherwise a plain increment. Because the
  // buffer depth is a power of two, natural overflow of the index bits
  // carries into the wrap bit, toggling it once per lap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_WIDTH'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rf_commit_buffer.sv
// In-order retirement buffer driving the register-file write port.
// Latency: writeback at edge N -> retire at edge N+1 -> rf_wen high after N+1.
// Backpressure: alloc_ready = !full from current occupancy; no early slot reuse.
module rf_commit_buffer
  import commit_pkg::*;
#(
  parameter int DEPTH          = DEPTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TAG_WIDTH      = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alloc_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alloc_rd,
  output logic                      alloc_ready,
  output logic [TAG_WIDTH-1:0]      alloc_tag,
  input  logic                      wb_valid,
  input  logic [TAG_WIDTH-1:0]      wb_tag,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      flush,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      commit_valid,
  output logic [TAG_WIDTH:0]        count
);

  localparam int PTR_WIDTH = TAG_WIDTH + 1;

  // Same field layout as commit_entry_t, but sized by this instance's
  // parameters so non-default register/data widths stay exact.
  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  logic [PTR_WIDTH-1:0] head_ptr;
  logic [PTR_WIDTH-1:0] tail_ptr;
  logic [TAG_WIDTH-1:0] head_idx;
  logic [TAG_WIDTH-1:0] tail_idx;
  logic                 empty;
  logic                 full;
  logic                 alloc_fire;
  logic                 retire_fire;
  entry_t               head_ent;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic                      commit_valid_q;
  logic                      commit_valid_d;
  logic                      rf_wen_q;
  logic                      rf_wen_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_d;
  logic [DATA_WIDTH-1:0]     rf_wdata_q;
  logic [DATA_WIDTH-1:0]     rf_wdata_d;

  // Head and tail pointers; flush returns both to slot 0 with wrap bit 0.
  wrap_ptr #(
    .PTR_WIDTH (PTR_WIDTH)
  ) u_head_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .inc   (retire_fire),
    .ptr   (head_ptr)
  );

  wrap_ptr #(
    .PTR_WIDTH (PTR_WIDTH)
  ) u_tail_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .inc   (alloc_fire),
    .ptr   (tail_ptr)
  );

  assign head_idx = head_ptr[TAG_WIDTH-1:0];
  assign tail_idx = tail_ptr[TAG_WIDTH-1:0];

  // Equal pointers mean empty; equal indices on different laps mean full.
  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_idx == tail_idx) &&
                 (head_ptr[TAG_WIDTH] != tail_ptr[TAG_WIDTH]);

  // Pointer difference is the occupancy; modular arithmetic over the
  // extra wrap bit yields 0..DEPTH without ambiguity.
  assign count = tail_ptr - head_ptr;

  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign head_ent    = ent_q[head_idx];
  assign retire_fire = !empty && head_ent.valid && head_ent.done;

  // Entry update: flush wipes everything; otherwise apply allocation,
  // then writeback, then retirement. Writeback looks at the registered
  // valid bit, so a result aimed at the slot being allocated this cycle
  // is dropped, and clearing the retiring head last makes a late
  // writeback to that slot harmless.
  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
    end else begin
      if (alloc_fire) begin
        ent_d[tail_idx].valid = 1'b1;
        ent_d[tail_idx].done  = 1'b0;
        ent_d[tail_idx].rd    = alloc_rd;
        ent_d[tail_idx].data  = '0;
      end
      if (wb_valid && ent_q[wb_tag].valid) begin
        ent_d[wb_tag].done = 1'b1;
        ent_d[wb_tag].data = wb_data;
      end
      if (retire_fire) begin
        ent_d[head_idx] = '0;
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Register-file port: pulse on retirement, x0 retires without a write.
  // Address and data hold between retirements.
  always_comb begin
    commit_valid_d = 1'b0;
    rf_wen_d       = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    if (retire_fire && !flush) begin
      commit_valid_d = 1'b1;
      rf_wen_d       = (head_ent.rd != REG_ADDR_WIDTH'(X0_ADDR));
      rf_waddr_d     = head_ent.rd;
      rf_wdata_d     = head_ent.data;
    end
  end

  // Output registers; async reset clears them without waiting for a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_valid_q <= 1'b0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;

endmodule
